// File: rtl/edge_trigger_pkg.sv
// Shared video-pipeline constants for the edge detector: edge-mode encoding
// and the synchroniser depth range check.
package edge_trigger_pkg;

   localparam int EDGE_RISE       = 1;
   localparam int EDGE_FALL       = 0;
   localparam int SYNC_STAGES_MAX = 3;

   typedef enum logic [1:0] {
      DET_FALL = 2'd0,
      DET_RISE = 2'd1,
      DET_BOTH = 2'd2
   } det_mode_e;

   function automatic bit sync_stages_ok(input int stages);
      return (stages >= 0) && (stages <= SYNC_STAGES_MAX);
   endfunction

   // BOTH overrides the POSEDGE selection.
   function automatic det_mode_e det_mode(input int posedge_sel, input int both);
      if (both != 0) return DET_BOTH;
      if (posedge_sel == EDGE_RISE) return DET_RISE;
      return DET_FALL;
   endfunction

endpackage

// File: rtl/edge_trigger_sync_chain.sv
// WIDTH x STAGES flop synchroniser, clocked every cycle, cleared by async reset.
module sync_chain
   import edge_trigger_pkg::*;
#(
   parameter int WIDTH  = 1,
   parameter int STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [STAGES];
   logic [WIDTH-1:0] stage_d [STAGES];

   always_comb begin
      stage_d[0] = d_i;
      for (int k = 1; k < STAGES; k++) begin
         stage_d[k] = stage_q[k-1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            stage_q[k] <= stage_d[k];
         end
      end
   end

   assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/edge_trigger.sv
// Enable-qualified edge detector: one EDGE pulse per selected transition on S,
// reported on the first En clock that sees it; first En after reset only arms.
module edge_trigger
   import edge_trigger_pkg::*;
#(
   parameter int POSEDGE     = EDGE_RISE,
   parameter int WIDTH       = 1,
   parameter int SYNC_STAGES = 0,
   parameter int BOTH        = 0
) (
   input  logic             CLK,
   input  logic             nRESET,
   input  logic [WIDTH-1:0] IN,
   input  logic             En,
   output logic [WIDTH-1:0] EDGE
);

   localparam det_mode_e MODE = det_mode(POSEDGE, BOTH);

   if (!sync_stages_ok(SYNC_STAGES) || (WIDTH < 1)) begin : g_param_check
      $error("edge_trigger: SYNC_STAGES must be 0..3 and WIDTH must be >= 1");
   end

   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] prev_q;
   logic [WIDTH-1:0] prev_d;
   logic             armed_q;
   logic             armed_d;

   if (SYNC_STAGES > 0) begin : g_sync
      sync_chain #(
         .WIDTH  (WIDTH),
         .STAGES (SYNC_STAGES)
      ) u_sync (
         .clk_i   (CLK),
         .rst_n_i (nRESET),
         .d_i     (IN),
         .q_o     (s)
      );
   end else begin : g_nosync
      assign s = IN;
   end

   always_comb begin
      prev_d  = prev_q;
      armed_d = armed_q;
      if (En) begin
         prev_d  = s;
         armed_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         prev_q  <= '0;
         armed_q <= 1'b0;
      end else begin
         prev_q  <= prev_d;
         armed_q <= armed_d;
      end
   end

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      logic det;
      if (MODE == DET_BOTH) begin : g_both
         assign det = s[i] ^ prev_q[i];
      end else if (MODE == DET_RISE) begin : g_rise
         assign det = s[i] & ~prev_q[i];
      end else begin : g_fall
         assign det = ~s[i] & prev_q[i];
      end
      assign EDGE[i] = En & armed_q & det;
   end

endmodule

// File: tb/tb_edge_trigger.sv
// Self-checking bench: four edge_trigger configurations on a shared clock,
// checked every cycle against a last-sample reference model.
module tb_edge_trigger;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       in_r;
   logic       in_f;
   logic [3:0] in_b;
   logic       edge_r;
   logic       edge_f;
   logic [3:0] edge_b0;
   logic [3:0] edge_b2;

   always #5 clk = ~clk;

   edge_trigger #(.POSEDGE(1)) u_rise (
      .CLK(clk), .nRESET(rst_n), .IN(in_r), .En(en), .EDGE(edge_r));
   edge_trigger #(0) u_fall (
      .CLK(clk), .nRESET(rst_n), .IN(in_f), .En(en), .EDGE(edge_f));
   edge_trigger #(.WIDTH(4), .SYNC_STAGES(0), .BOTH(1)) u_both0 (
      .CLK(clk), .nRESET(rst_n), .IN(in_b), .En(en), .EDGE(edge_b0));
   edge_trigger #(.WIDTH(4), .SYNC_STAGES(2), .BOTH(1)) u_both2 (
      .CLK(clk), .nRESET(rst_n), .IN(in_b), .En(en), .EDGE(edge_b2));

   // reference model: last value seen at an En clock, armed flag, input history
   logic       m_armed;
   logic       m_prev_r;
   logic       m_prev_f;
   logic [3:0] m_prev_b0;
   logic [3:0] m_prev_b2;
   logic [3:0] hist_b[$];

   logic       last_r;
   logic       last_f;
   logic [3:0] last_b0;
   logic [3:0] last_b2;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic check_int(input string tag, input int obs, input int exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      m_armed   = 1'b0;
      m_prev_r  = 1'b0;
      m_prev_f  = 1'b0;
      m_prev_b0 = 4'b0;
      m_prev_b2 = 4'b0;
      hist_b.delete();
   endtask

   // Entered at posedge+1: drive one cycle, check at the negedge, advance model.
   task automatic run(input logic r, input logic f, input logic [3:0] b, input logic e);
      logic [3:0] s_b2;
      in_r = r;
      in_f = f;
      in_b = b;
      en   = e;
      s_b2 = (hist_b.size() >= 2) ? hist_b[hist_b.size()-2] : 4'b0;
      #4;
      last_r  = edge_r;
      last_f  = edge_f;
      last_b0 = edge_b0;
      last_b2 = edge_b2;
      check("rise",    {3'b0, edge_r}, {3'b0, e & m_armed & r & ~m_prev_r});
      check("fall",    {3'b0, edge_f}, {3'b0, e & m_armed & ~f & m_prev_f});
      check("both_s0", edge_b0, {4{e & m_armed}} & (b ^ m_prev_b0));
      check("both_s2", edge_b2, {4{e & m_armed}} & (s_b2 ^ m_prev_b2));
      @(posedge clk);
      hist_b.push_back(b);
      if (e) begin
         m_prev_r  = r;
         m_prev_f  = f;
         m_prev_b0 = b;
         m_prev_b2 = s_b2;
         m_armed   = 1'b1;
      end
      #1;
   endtask

   // Entered at posedge+1: assert reset mid-cycle, hold two clocks, release mid-cycle.
   task automatic do_reset(input logic r, input logic f, input logic [3:0] b, input logic e);
      in_r  = r;
      in_f  = f;
      in_b  = b;
      en    = e;
      rst_n = 1'b0;
      #1;
      check("rst_rise",    {3'b0, edge_r}, 4'b0);
      check("rst_fall",    {3'b0, edge_f}, 4'b0);
      check("rst_both_s0", edge_b0, 4'b0);
      check("rst_both_s2", edge_b2, 4'b0);
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      logic r_seq   [6];
      logic exp_seq [6];
      int   pulses;
      int   t_b0_a, t_b2_a, t_b2_b;
      logic [3:0] b;

      rst_n = 1'b0;
      en    = 1'b0;
      in_r  = 1'b0;
      in_f  = 1'b0;
      in_b  = 4'b0;
      model_clear();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // rising edge, En continuous, first En after reset arms only
      r_seq   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      exp_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      for (int k = 0; k < 6; k++) begin
         run(r_seq[k], 1'b0, 4'b0, 1'b1);
         check("rise_table", {3'b0, last_r}, {3'b0, exp_seq[k]});
      end

      // falling edge with En every 4th clock; the later rise must not pulse
      pulses = 0;
      for (int k = 0; k < 24; k++) begin
         run(1'b0, (k < 6) || (k >= 17), 4'b0, (k % 4) == 3);
         if (last_f) pulses++;
      end
      check_int("fall_pulse_count", pulses, 1);

      // 2-clock pulse between En strobes is invisible
      pulses = 0;
      for (int k = 0; k < 16; k++) begin
         run((k == 4) || (k == 5), 1'b1, 4'b0, (k % 4) == 3);
         if (last_r) pulses++;
      end
      check_int("glitch_pulse_count", pulses, 0);

      // BOTH, 4 lanes: synchronised copy lags by 2 clocks
      t_b0_a = -100;
      t_b2_a = -100;
      t_b2_b = -100;
      for (int k = 0; k < 16; k++) begin
         b = (k < 4) ? 4'b0000 : (k < 8) ? 4'b1010 : 4'b0011;
         run(1'b0, 1'b1, b, 1'b1);
         if (k >= 2 && last_b0 == 4'b1010 && t_b0_a < 0) t_b0_a = k;
         if (k >= 2 && last_b2 == 4'b1010 && t_b2_a < 0) t_b2_a = k;
         if (k >= 2 && last_b2 == 4'b1001 && t_b2_b < 0) t_b2_b = k;
      end
      check_int("both_sync_latency", t_b2_a - t_b0_a, 2);
      check_int("both_second_edge",  t_b2_b - t_b2_a, 4);

      // reset mid-stream with IN high: no false edge on the arming strobe
      do_reset(1'b1, 1'b1, 4'b1111, 1'b1);
      run(1'b1, 1'b1, 4'b1111, 1'b1);
      check("rearm_no_edge", {3'b0, last_r}, 4'b0);
      run(1'b0, 1'b1, 4'b1111, 1'b1);
      run(1'b1, 1'b1, 4'b1111, 1'b1);
      check("rearm_rise", {3'b0, last_r}, 4'b0001);

      // randomized traffic, mixed En densities
      for (int k = 0; k < 400; k++) begin
         run(1'($urandom), 1'($urandom), 4'($urandom),
             (k < 200) ? 1'($urandom) : ($urandom_range(0, 3) == 0));
      end

      // HSYNC: 4 clocks high, 16 low, sampled 1-in-4
      pulses = 0;
      for (int k = 0; k < 120; k++) begin
         run(1'($urandom), (k % 20) < 4, 4'($urandom), (k % 4) == 3);
         if (last_f) pulses++;
      end
      check_int("hsync_pulse_count", pulses, 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
